// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Prefetch FIFO between fetch and decode. Each accepted fetch beat stores an
//   instruction word plus its address. The oldest entry is presented to decode
//   through a valid/ready handshake. A taken branch (flush_i) empties the queue
//   on the next edge so no wrong-path instruction reaches decode.
//
// Ports
//   clk_i                 clock, all state changes on the rising edge
//   rst_ni                asynchronous active-low reset
//   fetch_valid_i         fetch beat valid
//   fetch_address_i       address of the fetched instruction
//   fetch_instruction_i   fetched instruction word
//   fetch_ready_o         queue accepts a push (not full)
//   flush_i               branch taken, discard every entry
//   decode_valid_o        head entry valid (not empty)
//   decode_ready_i        decode consumes the head entry
//   decode_instruction_o  head instruction, NOP when empty
//   decode_address_o      head address, 0 when empty
//   count_o               occupied entries, 0..DEPTH
//
// Control view
//   state      | meaning
//   ST_EMPTY   | count == 0, decode_valid low
//   ST_PARTIAL | 0 < count < DEPTH, push and pop both allowed
//   ST_FULL    | count == DEPTH, pushes refused
module instruction_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned AW    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       fetch_valid_i,
  input  logic [AW-1:0]              fetch_address_i,
  input  logic [IW-1:0]              fetch_instruction_i,
  output logic                       fetch_ready_o,
  input  logic                       flush_i,
  output logic                       decode_valid_o,
  input  logic                       decode_ready_i,
  output logic [IW-1:0]              decode_instruction_o,
  output logic [AW-1:0]              decode_address_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] NOP      = IW'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  logic [IW-1:0] instr_q [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q;
  logic          push, pop;

  // Ready and valid come straight from the registered state, so there is no
  // combinational path from decode_ready_i to fetch_ready_o.
  assign fetch_ready_o  = (state_q != ST_FULL);
  assign decode_valid_o = (state_q != ST_EMPTY);
  assign count_o        = count_q;

  assign push    = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop     = decode_valid_o & decode_ready_i & ~flush_i;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      // Pointers wrap by natural overflow since DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      unique case (state_q)
        ST_EMPTY: begin
          if (push) state_q <= ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (push && !pop && count_q == CNT_LAST)      state_q <= ST_FULL;
          else if (pop && !push && count_q == CNT_ONE)  state_q <= ST_EMPTY;
        end
        ST_FULL: begin
          if (pop) state_q <= ST_PARTIAL;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // Storage is never cleared; validity is tracked solely by count/state.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_ptr_q] <= fetch_instruction_i;
      addr_q[wr_ptr_q]  <= fetch_address_i;
    end
  end

  assign decode_instruction_o = decode_valid_o ? instr_q[rd_ptr_q] : NOP;
  assign decode_address_o     = decode_valid_o ? addr_q[rd_ptr_q]  : '0;

  // Count and state must always agree on full/empty.
  a_full_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_FULL) == (count_q == CNT_FULL));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_ni;
  logic        fetch_valid_i;
  logic [31:0] fetch_address_i;
  logic [31:0] fetch_instruction_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic        decode_valid_o;
  logic        decode_ready_i;
  logic [31:0] decode_instruction_o;
  logic [31:0] decode_address_o;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  // Scoreboard of {address, instruction} for entries the queue should hold.
  logic [63:0] sb[$];
  int          mc = 0;

  instruction_fetch_queue #(.DEPTH(DEPTH), .IW(32), .AW(32)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_address_i     (fetch_address_i),
    .fetch_instruction_i (fetch_instruction_i),
    .fetch_ready_o       (fetch_ready_o),
    .flush_i             (flush_i),
    .decode_valid_o      (decode_valid_o),
    .decode_ready_i      (decode_ready_i),
    .decode_instruction_o(decode_instruction_o),
    .decode_address_o    (decode_address_o),
    .count_o             (count_o)
  );

  always begin
    #5;
    if (clk_en) clk_i = ~clk_i;
  end

  // One clock cycle: drive inputs, compare outputs at the falling edge against
  // the scoreboard, then advance the bench's own occupancy model at the edge.
  task automatic step(input logic fv, input logic [31:0] addr, input logic [31:0] instr,
                      input logic dr, input logic fl);
    logic pu, po;
    logic [63:0] head;
    fetch_valid_i       = fv;
    fetch_address_i     = addr;
    fetch_instruction_i = instr;
    decode_ready_i      = dr;
    flush_i             = fl;
    @(negedge clk_i);
    checks++;
    if (count_o !== 3'(mc)) begin
      errors++; $display("FAIL count: got %0d want %0d", count_o, mc);
    end
    checks++;
    if (decode_valid_o !== (mc != 0)) begin
      errors++; $display("FAIL decode_valid: got %b want %b", decode_valid_o, (mc != 0));
    end
    checks++;
    if (fetch_ready_o !== (mc != DEPTH)) begin
      errors++; $display("FAIL fetch_ready: got %b want %b", fetch_ready_o, (mc != DEPTH));
    end
    head = (mc != 0) ? sb[0] : {32'h0, 32'h0000_0013};
    checks++;
    if ({decode_address_o, decode_instruction_o} !== head) begin
      errors++;
      $display("FAIL decode_head: got %h@%h want %h@%h", decode_instruction_o,
               decode_address_o, head[31:0], head[63:32]);
    end
    pu = fv && (mc < DEPTH) && !fl;
    po = dr && (mc > 0) && !fl;
    @(posedge clk_i);
    #1;
    if (fl) begin
      sb.delete();
      mc = 0;
    end else begin
      if (po) begin void'(sb.pop_front()); mc--; end
      if (pu) begin sb.push_back({addr, instr}); mc++; end
    end
    fetch_valid_i  = 1'b0;
    decode_ready_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b1, 32'(base + i), 32'hA000_0000 + 32'(base + i), 1'b0, 1'b0);
  endtask

  task automatic drain;
    int guard = 0;
    while (mc > 0 && guard < 20) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      guard++;
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    fetch_valid_i = 1'b0; fetch_address_i = '0; fetch_instruction_i = '0;
    decode_ready_i = 1'b0; flush_i = 1'b0;
    #20;
    checks++;
    if (count_o !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count_o); end
    checks++;
    if (decode_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", decode_valid_o); end
    checks++;
    if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", fetch_ready_o); end
    checks++;
    if (decode_instruction_o !== 32'h0000_0013) begin
      errors++; $display("FAIL rst_instr: got %h want 00000013", decode_instruction_o);
    end
    checks++;
    if (decode_address_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", decode_address_o); end
    rst_ni = 1'b1;
    clk_en = 1'b1;
    @(posedge clk_i); #1;
    // Mid-cycle reset with three entries held.
    push_n(3, 32'h20);
    #3;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0) begin errors++; $display("FAIL async_rst_count: got %0d want 0", count_o); end
    checks++;
    if (decode_valid_o !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b want 0", decode_valid_o); end
    checks++;
    if (decode_instruction_o !== 32'h0000_0013) begin
      errors++; $display("FAIL async_rst_instr: got %h want 00000013", decode_instruction_o);
    end
    rst_ni = 1'b1;
    sb.delete();
    mc = 0;
    @(posedge clk_i); #1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_drain;
    step(1'b1, 32'd0, 32'h00208FE3, 1'b0, 1'b0);
    step(1'b1, 32'd1, 32'h000100B3, 1'b0, 1'b0);
    step(1'b1, 32'd2, 32'h00058133, 1'b0, 1'b0);
    step(1'b1, 32'd3, 32'hFE000FCB, 1'b0, 1'b0);
    checks++;
    if (fetch_ready_o !== 1'b0 || count_o !== 3'd4) begin
      errors++; $display("FAIL fill_full: got ready=%b count=%0d want ready=0 count=4", fetch_ready_o, count_o);
    end
    step(1'b1, 32'd4, 32'h11111111, 1'b0, 1'b0);
    checks++;
    if (count_o !== 3'd4) begin errors++; $display("FAIL refused_push: got count=%0d want 4", count_o); end
    drain();
  endtask

  task automatic test_simultaneous;
    push_n(2, 32'h40);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + 32'(i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    checks++;
    if (count_o !== 3'd2) begin errors++; $display("FAIL simul_count: got %0d want 2", count_o); end
    drain();
  endtask

  task automatic test_full_pop;
    push_n(4, 32'h60);
    step(1'b1, 32'h70, 32'hC0DE_0070, 1'b1, 1'b0);
    checks++;
    if (count_o !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d want 3", count_o); end
    drain();
  endtask

  task automatic test_flush;
    push_n(3, 32'h80);
    step(1'b1, 32'h90, 32'hDEAD_BEEF, 1'b1, 1'b1);
    checks++;
    if (count_o !== 3'd0 || decode_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_empty: got count=%0d valid=%b want 0/0", count_o, decode_valid_o);
    end
    step(1'b1, 32'd1, 32'h000100B3, 1'b0, 1'b0);
    checks++;
    if (decode_instruction_o !== 32'h000100B3 || decode_address_o !== 32'd1) begin
      errors++; $display("FAIL post_flush_push: got %h@%h want 000100b3@1", decode_instruction_o, decode_address_o);
    end
    drain();
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
      if (mc == 3) begin
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_full_pop();
    test_flush();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
